// File: rtl/bshift_pkg.sv
// Shared types for the pipelined barrel shifter: shift modes and per-stage control.
// The rotate datapath is only built when BSHIFT_ROTATE_EN is defined.
package bshift_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   // Control that rides along with every word: the mode and the original MSB for SRA fill.
   typedef struct packed {
      op_e  op;
      logic sign;
   } ctl_t;

endpackage

// File: rtl/bshift_if.sv
// Operand/result handshake bundle for barrel_shift_pipe.
interface bshift_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [SHW-1:0]       in_amt;
   bshift_pkg::op_e      in_op;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;

   modport master (
      output in_valid, in_data, in_amt, in_op, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/barrel_shift_pipe_stage.sv
// One level of the barrel shifter: conditional shift by 2^K, then payload/valid registers.
// Build option: BSHIFT_ROTATE_EN (undefined -> op 11 behaves as SRL).
module shift_stage
   import bshift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int K     = 0,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             v_in,
   input  logic [WIDTH-1:0] word_in,
   input  logic [SHW-1:0]   amt_in,
   input  op_e              op_in,
   input  logic             sign_in,
   input  logic             en_next,
   output logic             en,
   output logic             v_q,
   output logic [WIDTH-1:0] word_q,
   output logic [SHW-1:0]   amt_q,
   output op_e              op_q,
   output logic             sign_q
);

   localparam int S = 1 << K;

   typedef struct packed {
      logic [WIDTH-1:0] word;
      logic [SHW-1:0]   amt;
      ctl_t             ctl;
   } payload_t;

   payload_t         pl_d;
   payload_t         pl_q;
   logic [WIDTH-1:0] shifted;

   // SRA fills from the original MSB, so successive levels compose into one arithmetic shift.
   always_comb begin
      case (op_in)
         OP_SLL:  shifted = word_in << S;
         OP_SRA:  shifted = {{S{sign_in}}, word_in[WIDTH-1:S]};
`ifdef BSHIFT_ROTATE_EN
         OP_ROR:  shifted = {word_in[S-1:0], word_in[WIDTH-1:S]};
`endif
         default: shifted = {{S{1'b0}}, word_in[WIDTH-1:S]};
      endcase
      pl_d.word     = amt_in[K] ? shifted : word_in;
      pl_d.amt      = amt_in;
      pl_d.ctl.op   = op_in;
      pl_d.ctl.sign = sign_in;
   end

   // An empty slot always accepts, so bubbles collapse under back-pressure.
   assign en = !v_q || en_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q  <= 1'b0;
         pl_q <= '0;
      end else if (en) begin
         v_q  <= v_in;
         pl_q <= pl_d;
      end
   end

   assign word_q = pl_q.word;
   assign amt_q  = pl_q.amt;
   assign op_q   = pl_q.ctl.op;
   assign sign_q = pl_q.ctl.sign;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Fully pipelined barrel shifter (SLL/SRL/SRA/ROR), one register per mux level, valid/ready both sides.
// Build option: BSHIFT_ROTATE_EN enables the rotate datapath; otherwise op 11 acts as SRL.
module barrel_shift_pipe
   import bshift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic    clk,
   input  logic    reset,
   bshift_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);

   // Index 0 is the accepted operand; index k+1 is the register set of level k.
   logic [SHW:0]     v_s;
   logic [WIDTH-1:0] word_s [SHW+1];
   logic [SHW-1:0]   amt_s  [SHW+1];
   op_e              op_s   [SHW+1];
   logic             sign_s [SHW+1];
   logic [SHW-1:0]   en_s;
   logic [SHW-1:0]   en_next;

   assign v_s[0]    = bus.in_valid;
   assign word_s[0] = bus.in_data;
   assign amt_s[0]  = bus.in_amt;
   assign op_s[0]   = bus.in_op;
   assign sign_s[0] = bus.in_data[WIDTH-1];

   // Downstream space seen by each level, derived from registered valids only.
   always_comb begin
      en_next          = '0;
      en_next[SHW-1]   = bus.out_ready;
      for (int k = SHW - 2; k >= 0; k--) begin
         en_next[k] = en_next[k+1] || !v_s[k+2];
      end
   end

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .K     (k),
         .SHW   (SHW)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .v_in    (v_s[k]),
         .word_in (word_s[k]),
         .amt_in  (amt_s[k]),
         .op_in   (op_s[k]),
         .sign_in (sign_s[k]),
         .en_next (en_next[k]),
         .en      (en_s[k]),
         .v_q     (v_s[k+1]),
         .word_q  (word_s[k+1]),
         .amt_q   (amt_s[k+1]),
         .op_q    (op_s[k+1]),
         .sign_q  (sign_s[k+1])
      );
   end

   // The last level's registers are the output registers.
   assign bus.in_ready  = en_s[0] && !reset;
   assign bus.out_valid = v_s[SHW];
   assign bus.out_data  = word_s[SHW];

   logic unused_tail;
   assign unused_tail = ^{amt_s[SHW], op_s[SHW], sign_s[SHW], en_s};

endmodule
